// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller between the X/M and M/W pipeline registers.
// Issues a single-cycle request to a variable-latency data memory, stalls the
// upstream pipeline until mem_done (or a timeout), and feeds bubbles to
// writeback while the access is outstanding.
// Optional feature: define MEM_ALIGN_CHK_EN to trap odd-address memory
// operations without issuing them to memory.
//
// state | meaning
// IDLE  | no access outstanding; memops issue from here
// WAIT  | request issued, waiting for mem_done or timeout
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    input  logic [15:0] alu_out_in,
    input  logic [15:0] reg2data_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    input  logic        halt_in,
    input  logic [2:0]  writereg_in,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall_out,
    output logic [15:0] pc_out,
    output logic [15:0] alu_out_out,
    output logic [15:0] mem_data_out,
    output logic        MemToReg_out,
    output logic        RegWrite_out,
    output logic        halt_out,
    output logic        err_out,
    output logic [2:0]  writereg_out
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       memop;
    logic       misalign;
    logic       issue;
    logic       conflict;
    logic       timeout_hit;

    assign memop    = MemRead_in | MemWrite_in;
    assign conflict = MemRead_in & MemWrite_in;

`ifdef MEM_ALIGN_CHK_EN
    assign misalign = memop & alu_out_in[0];
`else
    assign misalign = 1'b0;
`endif

    assign issue       = (state == IDLE) & memop & ~misalign;
    assign timeout_hit = (state == WAIT) & ~mem_done & (cnt == 4'(TIMEOUT - 1));

    // Memory-side signals are combinational so the request leaves in the same
    // cycle the memop sits in X/M; a conflicting read+write is issued as a write.
    assign mem_addr  = alu_out_in;
    assign mem_wdata = reg2data_in;
    assign mem_wr    = MemWrite_in;
    assign mem_en    = rst & issue;
    assign stall_out = rst & (issue | ((state == WAIT) & ~mem_done & ~timeout_hit));

    // Access FSM and M/W output registers; every cycle defaults to a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            pc_out       <= 16'd0;
            alu_out_out  <= 16'd0;
            mem_data_out <= 16'd0;
            MemToReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
            halt_out     <= 1'b0;
            err_out      <= 1'b0;
            writereg_out <= 3'd0;
        end else begin
            pc_out       <= 16'd0;
            alu_out_out  <= 16'd0;
            mem_data_out <= 16'd0;
            MemToReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
            halt_out     <= 1'b0;
            err_out      <= 1'b0;
            writereg_out <= 3'd0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= WAIT;
                        cnt   <= 4'd0;
                    end else begin
                        pc_out       <= pc_in;
                        alu_out_out  <= alu_out_in;
                        MemToReg_out <= MemToReg_in;
                        writereg_out <= writereg_in;
                        if (misalign) begin
                            halt_out <= 1'b1;
                            err_out  <= 1'b1;
                        end else begin
                            RegWrite_out <= RegWrite_in;
                            halt_out     <= halt_in;
                        end
                    end
                end
                WAIT: begin
                    if (mem_done || timeout_hit) begin
                        state        <= IDLE;
                        cnt          <= 4'd0;
                        pc_out       <= pc_in;
                        alu_out_out  <= alu_out_in;
                        MemToReg_out <= MemToReg_in;
                        writereg_out <= writereg_in;
                        if (mem_done) begin
                            mem_data_out <= MemWrite_in ? 16'd0 : mem_rdata;
                            RegWrite_out <= RegWrite_in & ~conflict;
                            halt_out     <= halt_in;
                            err_out      <= conflict;
                        end else begin
                            halt_out <= 1'b1;
                            err_out  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl (TIMEOUT = 15).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_in, alu_out_in, reg2data_in, mem_rdata;
    logic        MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in, halt_in, mem_done;
    logic [2:0]  writereg_in;
    logic [15:0] mem_addr, mem_wdata, pc_out, alu_out_out, mem_data_out;
    logic        mem_en, mem_wr, stall_out, MemToReg_out, RegWrite_out, halt_out, err_out;
    logic [2:0]  writereg_out;

    int checks = 0;
    int errors = 0;

    wire [3:0] flags = {RegWrite_out, MemToReg_out, halt_out, err_out};

    mem_access_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_in), .alu_out_in(alu_out_in), .reg2data_in(reg2data_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
        .RegWrite_in(RegWrite_in), .halt_in(halt_in), .writereg_in(writereg_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_out(stall_out),
        .pc_out(pc_out), .alu_out_out(alu_out_out), .mem_data_out(mem_data_out),
        .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out), .halt_out(halt_out),
        .err_out(err_out), .writereg_out(writereg_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_instr(input logic [15:0] pc, input logic [15:0] addr, input logic [15:0] wd,
                             input logic rd, input logic wr, input logic m2r, input logic rw,
                             input logic hlt, input logic [2:0] wreg);
        pc_in = pc; alu_out_in = addr; reg2data_in = wd;
        MemRead_in = rd; MemWrite_in = wr; MemToReg_in = m2r; RegWrite_in = rw;
        halt_in = hlt; writereg_in = wreg;
    endtask

    task automatic set_nop();
        set_instr(16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        mem_done = 1'b0; mem_rdata = 16'd0;
    endtask

    // Drives mem_done 'lat' cycles after the request (0 = never) and counts
    // request strobes, stall cycles and non-bubble M/W loads during the stall.
    // Starts and ends at a negedge; on return the completing slot is in M/W.
    task automatic run_mem(input int lat, input logic [15:0] rdata,
                           output int n_en, output int n_stall, output int n_bad);
        logic fin = 1'b0;
        n_en = 0; n_stall = 0; n_bad = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            mem_done  = (lat > 0) && (k == lat);
            mem_rdata = mem_done ? rdata : 16'hDEAD;
            #1;
            n_en    += int'(mem_en);
            n_stall += int'(stall_out);
            if (!stall_out) fin = 1'b1;
            @(negedge clk);
            if (!fin && (flags != 4'b0 || alu_out_out != 16'd0 || pc_out != 16'd0)) n_bad++;
        end
        mem_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_instr(16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7);
        mem_done = 1'b0; mem_rdata = 16'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_en, stall_out} !== 2'b00) begin
            errors++; $display("FAIL reset_comb: en/stall=%b want 00", {mem_en, stall_out});
        end
        checks++;
        if ({flags, pc_out, alu_out_out, mem_data_out, writereg_out} !== '0) begin
            errors++; $display("FAIL reset_regs: flags=%b pc=%h alu=%h data=%h wreg=%0d want all 0",
                               flags, pc_out, alu_out_out, mem_data_out, writereg_out);
        end
        @(negedge clk);
        set_nop();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu();
        int stalls = 0;
        set_instr(16'h0100, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3);
        #1;
        stalls += int'(stall_out) + int'(mem_en);
        @(negedge clk);
        checks++;
        if (stalls !== 0) begin
            errors++; $display("FAIL alu_stall: stall/en seen=%0d want 0", stalls);
        end
        checks++;
        if ({alu_out_out, pc_out, writereg_out, flags, mem_data_out} !==
            {16'h0042, 16'h0100, 3'd3, 4'b1000, 16'h0000}) begin
            errors++; $display("FAIL alu_result: alu=%h pc=%h wreg=%0d flags=%b data=%h want 0042 0100 3 1000 0000",
                               alu_out_out, pc_out, writereg_out, flags, mem_data_out);
        end
        set_nop();
    endtask

    task automatic test_load();
        int n_en, n_stall, n_bad;
        set_instr(16'h0200, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5);
        #1;
        checks++;
        if ({mem_en, mem_wr, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
            errors++; $display("FAIL load_req: en=%b wr=%b addr=%h want 1 0 0010", mem_en, mem_wr, mem_addr);
        end
        run_mem(3, 16'hBEEF, n_en, n_stall, n_bad);
        checks++;
        if ({n_en, n_stall, n_bad} !== {32'd1, 32'd3, 32'd0}) begin
            errors++; $display("FAIL load_stall: en=%0d stall=%0d bad_bubbles=%0d want 1 3 0", n_en, n_stall, n_bad);
        end
        checks++;
        if ({mem_data_out, alu_out_out, pc_out, writereg_out, flags} !==
            {16'hBEEF, 16'h0010, 16'h0200, 3'd5, 4'b1100}) begin
            errors++; $display("FAIL load_result: data=%h alu=%h pc=%h wreg=%0d flags=%b want BEEF 0010 0200 5 1100",
                               mem_data_out, alu_out_out, pc_out, writereg_out, flags);
        end
        set_nop();
    endtask

    task automatic test_store();
        int n_en, n_stall, n_bad;
        set_instr(16'h0300, 16'h0020, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        #1;
        checks++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0020, 16'h1234}) begin
            errors++; $display("FAIL store_req: en=%b wr=%b addr=%h wdata=%h want 1 1 0020 1234",
                               mem_en, mem_wr, mem_addr, mem_wdata);
        end
        run_mem(1, 16'h7777, n_en, n_stall, n_bad);
        checks++;
        if ({n_en, n_stall, n_bad} !== {32'd1, 32'd1, 32'd0}) begin
            errors++; $display("FAIL store_stall: en=%0d stall=%0d bad_bubbles=%0d want 1 1 0", n_en, n_stall, n_bad);
        end
        checks++;
        if ({mem_data_out, alu_out_out, flags} !== {16'h0000, 16'h0020, 4'b0000}) begin
            errors++; $display("FAIL store_result: data=%h alu=%h flags=%b want 0000 0020 0000",
                               mem_data_out, alu_out_out, flags);
        end
        set_nop();
    endtask

    task automatic test_timeout();
        int n_en, n_stall, n_bad;
        set_instr(16'h0400, 16'h0030, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        run_mem(0, 16'h0000, n_en, n_stall, n_bad);
        checks++;
        if ({n_en, n_stall, n_bad} !== {32'd1, 32'd15, 32'd0}) begin
            errors++; $display("FAIL timeout_stall: en=%0d stall=%0d bad_bubbles=%0d want 1 15 0", n_en, n_stall, n_bad);
        end
        checks++;
        if ({flags, mem_data_out, writereg_out} !== {4'b0111, 16'h0000, 3'd2}) begin
            errors++; $display("FAIL timeout_result: flags=%b data=%h wreg=%0d want 0111 0000 2",
                               flags, mem_data_out, writereg_out);
        end
        set_nop();
        mem_done = 1'b1; mem_rdata = 16'h5555;
        #1;
        checks++;
        if ({mem_en, stall_out} !== 2'b00) begin
            errors++; $display("FAIL late_done_comb: en/stall=%b want 00", {mem_en, stall_out});
        end
        @(negedge clk);
        checks++;
        if ({flags, mem_data_out} !== {4'b0000, 16'h0000}) begin
            errors++; $display("FAIL late_done_regs: flags=%b data=%h want 0000 0000", flags, mem_data_out);
        end
        set_nop();
    endtask

    task automatic test_conflict();
        int n_en, n_stall, n_bad;
        set_instr(16'h0500, 16'h0040, 16'hAAAA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);
        #1;
        checks++;
        if ({mem_en, mem_wr} !== 2'b11) begin
            errors++; $display("FAIL conflict_req: en=%b wr=%b want 1 1", mem_en, mem_wr);
        end
        run_mem(2, 16'h9999, n_en, n_stall, n_bad);
        checks++;
        if ({n_stall, flags, mem_data_out} !== {32'd2, 4'b0101, 16'h0000}) begin
            errors++; $display("FAIL conflict_result: stall=%0d flags=%b data=%h want 2 0101 0000",
                               n_stall, flags, mem_data_out);
        end
        set_nop();
    endtask

    task automatic test_halt_store();
        int n_en, n_stall, n_bad;
        set_instr(16'h0600, 16'h0050, 16'h4321, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        run_mem(2, 16'h0000, n_en, n_stall, n_bad);
        checks++;
        if ({n_en, n_stall, n_bad, flags} !== {32'd1, 32'd2, 32'd0, 4'b0010}) begin
            errors++; $display("FAIL halt_store: en=%0d stall=%0d bad=%0d flags=%b want 1 2 0 0010",
                               n_en, n_stall, n_bad, flags);
        end
        set_nop();
    endtask

    task automatic test_reset_mid_wait();
        set_instr(16'h0700, 16'h0060, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd6);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_en, stall_out, flags, pc_out, alu_out_out, mem_data_out} !== '0) begin
            errors++; $display("FAIL rst_wait: en=%b stall=%b flags=%b pc=%h alu=%h data=%h want all 0",
                               mem_en, stall_out, flags, pc_out, alu_out_out, mem_data_out);
        end
        @(negedge clk);
        rst = 1'b1;
        set_instr(16'h0800, 16'h0077, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL rst_wait_idle: stall=%b want 0", stall_out);
        end
        @(negedge clk);
        checks++;
        if ({alu_out_out, flags, writereg_out} !== {16'h0077, 4'b1000, 3'd1}) begin
            errors++; $display("FAIL rst_wait_next: alu=%h flags=%b wreg=%0d want 0077 1000 1",
                               alu_out_out, flags, writereg_out);
        end
        set_nop();
        mem_done = 1'b1; mem_rdata = 16'h6666;
        @(negedge clk);
        checks++;
        if ({flags, mem_data_out} !== {4'b0000, 16'h0000}) begin
            errors++; $display("FAIL rst_wait_stale: flags=%b data=%h want 0000 0000", flags, mem_data_out);
        end
        set_nop();
    endtask

    task automatic test_misaligned();
`ifdef MEM_ALIGN_CHK_EN
        set_instr(16'h0900, 16'h0021, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3);
        #1;
        checks++;
        if ({mem_en, stall_out} !== 2'b00) begin
            errors++; $display("FAIL align_req: en/stall=%b want 00", {mem_en, stall_out});
        end
        @(negedge clk);
        checks++;
        if ({flags, alu_out_out} !== {4'b0111, 16'h0021}) begin
            errors++; $display("FAIL align_result: flags=%b alu=%h want 0111 0021", flags, alu_out_out);
        end
`else
        int n_en, n_stall, n_bad;
        set_instr(16'h0900, 16'h0021, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3);
        #1;
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 16'h0021}) begin
            errors++; $display("FAIL odd_req: en=%b addr=%h want 1 0021", mem_en, mem_addr);
        end
        run_mem(1, 16'hCAFE, n_en, n_stall, n_bad);
        checks++;
        if ({flags, mem_data_out} !== {4'b1100, 16'hCAFE}) begin
            errors++; $display("FAIL odd_result: flags=%b data=%h want 1100 CAFE", flags, mem_data_out);
        end
`endif
        set_nop();
    endtask

    task automatic test_back_to_back();
        int n_en, n_stall, n_bad;
        set_instr(16'h0A00, 16'h0080, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7);
        run_mem(1, 16'h0F0F, n_en, n_stall, n_bad);
        set_instr(16'h0A02, 16'h0090, 16'hF00D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        #1;
        checks++;
        if ({mem_data_out, writereg_out, mem_en, mem_wr} !== {16'h0F0F, 3'd7, 1'b1, 1'b1}) begin
            errors++; $display("FAIL b2b: data=%h wreg=%0d en=%b wr=%b want 0F0F 7 1 1",
                               mem_data_out, writereg_out, mem_en, mem_wr);
        end
        run_mem(3, 16'h0000, n_en, n_stall, n_bad);
        checks++;
        if ({n_en, n_stall, alu_out_out} !== {32'd1, 32'd3, 16'h0090}) begin
            errors++; $display("FAIL b2b_store: en=%0d stall=%0d alu=%h want 1 3 0090", n_en, n_stall, alu_out_out);
        end
        set_nop();
    endtask

    initial begin
        set_nop();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_conflict();
        test_halt_store();
        test_reset_mid_wait();
        test_misaligned();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
